// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = 8;
  localparam int unsigned ITER_W    = 5;

  localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_NORM = 3'd2,
    S_ITER = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } div_state_e;

  // Two's-complement negate; 0x8000_0000 maps to itself.
  function automatic logic [DIV_W-1:0] neg2(input logic [DIV_W-1:0] x);
    return ~x + DIV_W'(1);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/result bundle between the execute stage and the divider.
interface iter_divider_if;
  import div_pkg::*;

  logic             start;
  logic             is_signed;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/iter_divider.sv
// Multi-cycle 32-bit restoring divider; external leading-one encoders let it
// skip the leading-zero iterations of the quotient.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  iter_divider_if.slave    bus,
  output logic [WIDTH-1:0] enc_a,
  output logic [WIDTH-1:0] enc_b,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b
);

  div_state_e        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_signed;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_fix_en;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_dsh;
  logic [WIDTH-1:0]  r_q;
  logic [ITER_W-1:0] r_iter;

  logic [CNT_W-1:0]  w_k;
  logic              w_a_lt_b;
  logic              w_b_zero;

  // Shift distance from leading-one positions; zero tests use full magnitudes
  // because the encoder reports 0 for both 0 and 1.
  assign w_k      = cnt_a - cnt_b;
  assign w_a_lt_b = enc_a < enc_b;
  assign w_b_zero = (enc_b == '0);

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_signed      <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_fix_en      <= 1'b0;
      r_rem         <= '0;
      r_dsh         <= '0;
      r_q           <= '0;
      r_iter        <= '0;
      enc_a         <= '0;
      enc_b         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.dividend;
            r_b      <= bus.divisor;
            r_signed <= bus.is_signed;
            bus.busy <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          enc_a   <= (r_signed && r_a[WIDTH-1]) ? neg2(r_a) : r_a;
          enc_b   <= (r_signed && r_b[WIDTH-1]) ? neg2(r_b) : r_b;
          r_neg_q <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= r_signed & r_a[WIDTH-1];
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (w_b_zero) begin
            r_q      <= DIV0_QUOT;
            r_rem    <= r_a;
            r_fix_en <= 1'b0;
            r_state  <= S_FIX;
          end else if (w_a_lt_b) begin
            r_q      <= '0;
            r_rem    <= enc_a;
            r_fix_en <= 1'b1;
            r_state  <= S_FIX;
          end else begin
            r_q      <= '0;
            r_rem    <= enc_a;
            r_dsh    <= enc_b << w_k;
            r_iter   <= ITER_W'(w_k);
            r_fix_en <= 1'b1;
            r_state  <= S_ITER;
          end
        end
        S_ITER: begin
          if (r_rem >= r_dsh) begin
            r_rem       <= r_rem - r_dsh;
            r_q[r_iter] <= 1'b1;
          end
          r_dsh <= r_dsh >> 1;
          if (r_iter == '0) begin
            r_state <= S_FIX;
          end else begin
            r_iter <= r_iter - ITER_W'(1);
          end
        end
        S_FIX: begin
          bus.quotient  <= (r_fix_en && r_neg_q) ? neg2(r_q)   : r_q;
          bus.remainder <= (r_fix_en && r_neg_r) ? neg2(r_rem) : r_rem;
          bus.done      <= 1'b1;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider with a behavioural encoder pair.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] enc_a;
  logic [31:0] enc_b;
  logic [7:0]  cnt_a;
  logic [7:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  iter_divider_if bus ();

  iter_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
  );

  always #5 clk = ~clk;

  // Leading-one index; 0 for inputs 0 and 1.
  function automatic logic [7:0] lead_one(input logic [31:0] x);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  always_comb begin
    cnt_a = lead_one(enc_a);
    cnt_b = lead_one(enc_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present one request for a single clock edge; returns in cycle 1 after it.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; n is the cycle index, busy_ok whether busy held.
  task automatic wait_done(output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!bus.done && n < 64) begin
      busy_ok &= bus.busy;
      @(posedge clk);
      #1;
      n++;
    end
    busy_ok &= bus.busy;
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_q,
                     input logic [31:0] exp_r, input int exp_lat);
    int   n;
    logic bok;
    launch(sgn, a, b);
    wait_done(n, bok);
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".busy"}, 32'(bok), 32'd1);
    check({tag, ".q"}, bus.quotient, exp_q);
    check({tag, ".r"}, bus.remainder, exp_r);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   n;
    logic bok;
    logic seen_done;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.q", bus.quotient, 32'd0);
    check("rst.r", bus.remainder, 32'd0);
    check("rst.enc_a", enc_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("u100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         9);
    run("u5_9",    1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         4);
    run("u1_1",    1'b0, 32'd1,         32'd1,         32'd1,         32'd0,         5);
    run("sm7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 6);
    run("s7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         6);
    run("u_div0",  1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      4);
    run("s_div0",  1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 4);
    run("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         36);
    run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         36);

    // A new start while iterating must be ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 5;
    bok = 1'b1;
    while (!bus.done && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ign.lat", 32'(n), 32'd9);
    check("ign.q", bus.quotient, 32'd14);
    check("ign.r", bus.remainder, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("ign.no_restart", 32'(bus.busy), 32'd0);

    // Reset in the middle of iterating aborts without a done pulse.
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.q", bus.quotient, 32'd0);
    check("abort.r", bus.remainder, 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen_done |= bus.done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen_done |= bus.done;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    check("abort.idle", 32'(bus.busy), 32'd0);

    run("u20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
